// File: rtl/uart_mon_pkg.sv
// Shared state encoding and command/reply byte values for the UART memory monitor.
package uart_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADR2,
        ST_ADR1,
        ST_ADR0,
        ST_WDAT,
        ST_MEM,
        ST_TXW,
        ST_TXD
    } mon_state_e;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_VER   = 8'h3F;
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

endpackage

// File: rtl/uart_mon_timer.sv
// Reloadable down-counter; o_expire pulses on the COUNT-th enabled cycle after a load.
module uart_mon_timer #(
    parameter int COUNT = 1024
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(COUNT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(COUNT);
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_expire = i_en && !i_load && (r_cnt == W'(1));

endmodule

// File: rtl/uart_mem_monitor.sv
// UART debug bridge: decodes R/W/? byte commands, performs one RAM access, sends one reply byte.
module uart_mem_monitor
    import uart_mon_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 23,
    parameter int         RX_TIMEOUT  = 1_080_000,
    parameter int         MEM_TIMEOUT = 1024,
    parameter logic [7:0] VERSION     = 8'h01
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_STROBE,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [7:0]            RAM_DIN,
    input  logic [7:0]            RAM_DOUT,
    output logic                  RAM_OE,
    output logic                  RAM_WE,
    input  logic                  RAM_ACK,
    output logic                  BUSY,
    output logic [7:0]            OVERRUN
);
    mon_state_e            r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_din, r_tx_data, r_overrun;
    logic                  r_oe, r_we, r_tx_strobe, r_is_wr, r_seen_busy;
    logic                  w_rx_load, w_mem_load, w_drop, w_rx_exp, w_mem_exp, w_rx_en;

    assign w_rx_en = (r_state == ST_ADR2) || (r_state == ST_ADR1) ||
                     (r_state == ST_ADR0) || (r_state == ST_WDAT);

    uart_mon_timer #(.COUNT(RX_TIMEOUT)) u_rx_timer (
        .CLK(CLK), .RESET_n(RESET_n), .i_load(w_rx_load), .i_en(w_rx_en), .o_expire(w_rx_exp)
    );

    uart_mon_timer #(.COUNT(MEM_TIMEOUT)) u_mem_timer (
        .CLK(CLK), .RESET_n(RESET_n), .i_load(w_mem_load), .i_en(r_state == ST_MEM),
        .o_expire(w_mem_exp)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A byte arriving in the expiry cycle wins over the RX timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_rx_load   = 1'b0;
        w_mem_load  = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: if (RX_VALID) begin
                if (RX_DATA == CMD_READ || RX_DATA == CMD_WRITE) begin
                    w_state_nxt = ST_ADR2;
                    w_rx_load   = 1'b1;
                end else begin
                    w_state_nxt = ST_TXW;
                end
            end
            ST_ADR2: if (RX_VALID) begin
                w_state_nxt = ST_ADR1;
                w_rx_load   = 1'b1;
            end else if (w_rx_exp) w_state_nxt = ST_IDLE;
            ST_ADR1: if (RX_VALID) begin
                w_state_nxt = ST_ADR0;
                w_rx_load   = 1'b1;
            end else if (w_rx_exp) w_state_nxt = ST_IDLE;
            ST_ADR0: if (RX_VALID) begin
                w_state_nxt = r_is_wr ? ST_WDAT : ST_MEM;
                w_rx_load   = r_is_wr;
                w_mem_load  = !r_is_wr;
            end else if (w_rx_exp) w_state_nxt = ST_IDLE;
            ST_WDAT: if (RX_VALID) begin
                w_state_nxt = ST_MEM;
                w_mem_load  = 1'b1;
            end else if (w_rx_exp) w_state_nxt = ST_IDLE;
            ST_MEM: begin
                w_drop = RX_VALID;
                if (RAM_ACK || w_mem_exp) w_state_nxt = ST_TXW;
            end
            ST_TXW: begin
                w_drop = RX_VALID;
                if (!TX_BUSY) w_state_nxt = ST_TXD;
            end
            ST_TXD: begin
                w_drop = RX_VALID;
                if (r_seen_busy && !TX_BUSY) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_addr      <= '0;
            r_din       <= '0;
            r_tx_data   <= '0;
            r_overrun   <= '0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_tx_strobe <= 1'b0;
            r_is_wr     <= 1'b0;
            r_seen_busy <= 1'b0;
        end else begin
            r_tx_strobe <= (r_state == ST_TXW) && !TX_BUSY;
            if (w_drop && r_overrun != 8'hFF)
                r_overrun <= r_overrun + 8'd1;
            case (r_state)
                ST_IDLE: if (RX_VALID) begin
                    r_is_wr   <= (RX_DATA == CMD_WRITE);
                    r_tx_data <= (RX_DATA == CMD_VER) ? VERSION : REPLY_NAK;
                end
                // Shifting bytes in leaves A2..A0 in the low 24 bits; anything above ADDR_WIDTH falls off.
                ST_ADR2, ST_ADR1: if (RX_VALID)
                    r_addr <= ADDR_WIDTH'({r_addr, RX_DATA});
                ST_ADR0: if (RX_VALID) begin
                    r_addr <= ADDR_WIDTH'({r_addr, RX_DATA});
                    r_oe   <= !r_is_wr;
                end
                ST_WDAT: if (RX_VALID) begin
                    r_din <= RX_DATA;
                    r_we  <= 1'b1;
                end
                ST_MEM: if (RAM_ACK) begin
                    r_oe      <= 1'b0;
                    r_we      <= 1'b0;
                    r_tx_data <= r_is_wr ? REPLY_ACK : RAM_DOUT;
                end else if (w_mem_exp) begin
                    r_oe      <= 1'b0;
                    r_we      <= 1'b0;
                    r_tx_data <= REPLY_NAK;
                end
                ST_TXW:  r_seen_busy <= 1'b0;
                ST_TXD:  if (TX_BUSY) r_seen_busy <= 1'b1;
                default: ;
            endcase
        end
    end

    assign TX_DATA   = r_tx_data;
    assign TX_STROBE = r_tx_strobe;
    assign RAM_ADDR  = r_addr;
    assign RAM_DIN   = r_din;
    assign RAM_OE    = r_oe;
    assign RAM_WE    = r_we;
    assign BUSY      = (r_state != ST_IDLE);
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_mem_monitor.sv
// Bench for uart_mem_monitor: UART/RAM environment models plus a command-level reference model.
module tb_uart_mem_monitor;
    localparam int AW  = 23;
    localparam int RXT = 200;
    localparam int MT  = 64;

    logic          CLK = 1'b0;
    logic          RESET_n;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic [7:0]    TX_DATA;
    logic          TX_STROBE;
    logic          TX_BUSY;
    logic [AW-1:0] RAM_ADDR;
    logic [7:0]    RAM_DIN;
    logic [7:0]    RAM_DOUT = 8'h00;
    logic          RAM_OE;
    logic          RAM_WE;
    logic          RAM_ACK = 1'b0;
    logic          BUSY;
    logic [7:0]    OVERRUN;

    uart_mem_monitor #(.ADDR_WIDTH(AW), .RX_TIMEOUT(RXT), .MEM_TIMEOUT(MT), .VERSION(8'h01)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DATA(TX_DATA), .TX_STROBE(TX_STROBE), .TX_BUSY(TX_BUSY),
        .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT), .RAM_OE(RAM_OE),
        .RAM_WE(RAM_WE), .RAM_ACK(RAM_ACK), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // UART transmitter model: every strobe is logged and raises busy for a few cycles.
    logic       tx_hold = 1'b0;
    logic       tx_busy_m = 1'b0;
    int         tx_cnt = 0;
    logic [7:0] tx_q[$];
    int         tx_rd = 0;
    assign TX_BUSY = tx_hold | tx_busy_m;

    always @(negedge CLK) begin
        if (TX_STROBE) begin
            tx_q.push_back(TX_DATA);
            tx_cnt = 3;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        tx_busy_m = (tx_cnt > 0);
    end

    // RAM model: acks a held request after ram_delay cycles when enabled.
    bit         ram_en = 1'b1;
    int         ram_delay = 2;
    int         ram_wait = 0;
    logic [7:0] ram[int];

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h5A;
    endfunction

    always @(negedge CLK) begin
        RAM_ACK = 1'b0;
        if (ram_en && (RAM_OE || RAM_WE)) begin
            ram_wait++;
            if (ram_wait >= ram_delay) begin
                ram_wait = 0;
                RAM_ACK  = 1'b1;
                if (RAM_WE) ram[int'(RAM_ADDR)] = RAM_DIN;
                RAM_DOUT = ram.exists(int'(RAM_ADDR)) ? ram[int'(RAM_ADDR)] : init_byte(int'(RAM_ADDR));
            end
        end else begin
            ram_wait = 0;
        end
    end

    // Reference model: expected reply of a completed command, tracking written bytes.
    logic [7:0] ref_mem[int];

    function automatic logic [7:0] ref_reply(input logic [7:0] c, input logic [23:0] a, input logic [7:0] d);
        int ia;
        ia = int'(a % (24'd1 << AW));
        if (c == 8'h52) return ref_mem.exists(ia) ? ref_mem[ia] : init_byte(ia);
        if (c == 8'h57) begin
            ref_mem[ia] = d;
            return 8'h06;
        end
        if (c == 8'h3F) return 8'h01;
        return 8'h15;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [23:0] a, input logic [7:0] d, input bit gaps);
        send_byte(c);
        if (c == 8'h52 || c == 8'h57) begin
            for (int i = 2; i >= 0; i--) begin
                if (gaps) repeat ($urandom_range(0, 3)) tick();
                send_byte(a[i*8 +: 8]);
            end
            if (c == 8'h57) begin
                if (gaps) repeat ($urandom_range(0, 3)) tick();
                send_byte(d);
            end
        end
    endtask

    task automatic wait_reply(output logic [7:0] got, output int cnt);
        int t = 0;
        while ((tx_q.size() == tx_rd || BUSY) && t < 3000) begin
            tick();
            t++;
        end
        cnt = tx_q.size() - tx_rd;
        got = (cnt > 0) ? tx_q[tx_rd] : 8'hxx;
        tx_rd = tx_q.size();
    endtask

    task automatic test_reset();
        RESET_n = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
        repeat (3) tick();
        n_vec++;
        if ({TX_DATA, TX_STROBE, RAM_ADDR, RAM_DIN, RAM_OE, RAM_WE, BUSY, OVERRUN} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h required=0",
                     {TX_DATA, TX_STROBE, RAM_ADDR, RAM_DIN, RAM_OE, RAM_WE, BUSY, OVERRUN});
        end
        RESET_n = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (BUSY !== 1'b0 || TX_STROBE !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle busy=%b strobe=%b required 0 0", BUSY, TX_STROBE);
        end
    endtask

    task automatic test_version();
        logic [7:0] got;
        int cnt, t;
        bit rw_seen = 0;
        tick();
        RX_DATA = 8'h3F; RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        n_vec++;
        if (TX_STROBE !== 1'b0) begin
            n_err++; $display("FAIL ver_early_strobe got=%b required=0", TX_STROBE);
        end
        tick();
        n_vec++;
        if (TX_STROBE !== 1'b1 || TX_DATA !== 8'h01) begin
            n_err++; $display("FAIL ver_latency strobe=%b data=%h required 1 01", TX_STROBE, TX_DATA);
        end
        t = 0;
        while (BUSY && t < 100) begin
            if (RAM_OE || RAM_WE) rw_seen = 1;
            tick(); t++;
        end
        n_vec++;
        if (rw_seen) begin
            n_err++; $display("FAIL ver_no_ram got=1 required=0");
        end
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== 8'h01) begin
            n_err++; $display("FAIL ver_reply count=%0d data=%h required 1 01", cnt, got);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] got, exp;
        int cnt;
        ram_delay = 5;
        exp = ref_reply(8'h57, 24'h001234, 8'hA5);
        send_cmd(8'h57, 24'h001234, 8'hA5, 0);
        n_vec++;
        if (RAM_WE !== 1'b1 || RAM_OE !== 1'b0 || RAM_ADDR !== 23'h001234 || RAM_DIN !== 8'hA5) begin
            n_err++;
            $display("FAIL wr_request we=%b oe=%b addr=%h din=%h required 1 0 001234 a5",
                     RAM_WE, RAM_OE, RAM_ADDR, RAM_DIN);
        end
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== exp) begin
            n_err++; $display("FAIL wr_reply count=%0d data=%h required 1 %h", cnt, got, exp);
        end
        exp = ref_reply(8'h52, 24'h001234, 8'h00);
        send_cmd(8'h52, 24'h001234, 8'h00, 0);
        n_vec++;
        if (RAM_OE !== 1'b1 || RAM_WE !== 1'b0) begin
            n_err++; $display("FAIL rd_request oe=%b we=%b required 1 0", RAM_OE, RAM_WE);
        end
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== exp) begin
            n_err++; $display("FAIL rd_reply count=%0d data=%h required 1 %h", cnt, got, exp);
        end
        ram_delay = 2;
    endtask

    task automatic test_random();
        logic [7:0] got, exp, c, d;
        logic [23:0] a;
        int cnt;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: c = 8'h52;
                1: c = 8'h57;
                2: c = 8'h3F;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h52 || c == 8'h57 || c == 8'h3F) c = 8'($urandom);
                end
            endcase
            a = {($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00, 13'h0, 3'($urandom)};
            d = 8'($urandom);
            ram_delay = $urandom_range(1, 6);
            exp = ref_reply(c, a, d);
            send_cmd(c, a, d, 1);
            wait_reply(got, cnt);
            n_vec++;
            if (cnt != 1 || got !== exp) begin
                n_err++;
                $display("FAIL rand_cmd%0d c=%h a=%h count=%0d data=%h required 1 %h", i, c, a, cnt, got, exp);
            end
        end
        ram_delay = 2;
    endtask

    task automatic test_trunc();
        logic [7:0] got, exp;
        int cnt;
        exp = ref_reply(8'h52, 24'hFF0001, 8'h00);
        send_cmd(8'h52, 24'hFF0001, 8'h00, 0);
        n_vec++;
        if (RAM_ADDR !== 23'h7F0001 || RAM_OE !== 1'b1) begin
            n_err++; $display("FAIL trunc_addr addr=%h oe=%b required 7f0001 1", RAM_ADDR, RAM_OE);
        end
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== exp) begin
            n_err++; $display("FAIL trunc_reply count=%0d data=%h required 1 %h", cnt, got, exp);
        end
    endtask

    task automatic test_rx_timeout();
        logic [7:0] got, exp;
        int cnt;
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (RXT - 1) tick();
        n_vec++;
        if (BUSY !== 1'b1) begin
            n_err++; $display("FAIL rxto_before got busy=%b required=1", BUSY);
        end
        tick();
        n_vec++;
        if (BUSY !== 1'b0 || tx_q.size() != tx_rd) begin
            n_err++; $display("FAIL rxto_idle busy=%b replies=%0d required 0 0", BUSY, tx_q.size() - tx_rd);
        end
        // Third byte lands exactly in the expiry cycle and must be taken.
        exp = ref_reply(8'h52, 24'h000007, 8'h00);
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (RXT - 2) tick();
        send_byte(8'h00);
        send_byte(8'h07);
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== exp) begin
            n_err++; $display("FAIL rxto_edge_byte count=%0d data=%h required 1 %h", cnt, got, exp);
        end
    endtask

    task automatic test_mem_timeout();
        logic [7:0] got;
        int cnt, hi;
        ram_en = 0;
        send_cmd(8'h52, 24'h000100, 8'h00, 0);
        hi = 0;
        while (RAM_OE === 1'b1 && hi < MT + 10) begin
            hi++;
            tick();
        end
        n_vec++;
        if (hi != MT) begin
            n_err++; $display("FAIL memto_oe_cycles got=%0d required=%0d", hi, MT);
        end
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== 8'h15) begin
            n_err++; $display("FAIL memto_reply count=%0d data=%h required 1 15", cnt, got);
        end
        ram_en = 1;
    endtask

    task automatic test_overrun();
        logic [7:0] got, ov0, exp_ov;
        int cnt;
        ov0 = OVERRUN;
        tx_hold = 1'b1;
        send_byte(8'h3F);
        repeat (2) tick();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        exp_ov = (int'(ov0) + 3 > 255) ? 8'hFF : ov0 + 8'd3;
        n_vec++;
        if (OVERRUN !== exp_ov) begin
            n_err++; $display("FAIL overrun_3 got=%0d required=%0d", OVERRUN, exp_ov);
        end
        for (int i = 0; i < 260; i++) send_byte(8'($urandom));
        n_vec++;
        if (OVERRUN !== 8'hFF) begin
            n_err++; $display("FAIL overrun_sat got=%h required=ff", OVERRUN);
        end
        tx_hold = 1'b0;
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== 8'h01) begin
            n_err++; $display("FAIL overrun_reply count=%0d data=%h required 1 01", cnt, got);
        end
        send_cmd(8'h00, 24'h0, 8'h0, 0);
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== 8'h15 || OVERRUN !== 8'hFF) begin
            n_err++; $display("FAIL nak_reply count=%0d data=%h ovr=%h required 1 15 ff", cnt, got, OVERRUN);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        int cnt;
        ram_en = 0;
        send_cmd(8'h57, 24'h000055, 8'h3C, 0);
        n_vec++;
        if (RAM_WE !== 1'b1) begin
            n_err++; $display("FAIL rstmid_we_before got=%b required=1", RAM_WE);
        end
        #2 RESET_n = 1'b0;
        #1;
        n_vec++;
        if ({TX_DATA, TX_STROBE, RAM_ADDR, RAM_DIN, RAM_OE, RAM_WE, BUSY, OVERRUN} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs got=%h required=0",
                     {TX_DATA, TX_STROBE, RAM_ADDR, RAM_DIN, RAM_OE, RAM_WE, BUSY, OVERRUN});
        end
        repeat (2) tick();
        RESET_n = 1'b1;
        ram_en = 1;
        repeat (5) tick();
        tx_rd = tx_q.size();
        exp = ref_reply(8'h52, 24'h000055, 8'h00);
        send_cmd(8'h52, 24'h000055, 8'h00, 1);
        wait_reply(got, cnt);
        n_vec++;
        if (cnt != 1 || got !== exp) begin
            n_err++; $display("FAIL rstmid_next_cmd count=%0d data=%h required 1 %h", cnt, got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_version();
        test_write_read();
        test_random();
        test_trunc();
        test_rx_timeout();
        test_mem_timeout();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
